// File: rtl/ring_token_arbiter.sv
// Four-way round-robin arbiter with a rotating one-hot priority token, registered
// one-hot grant, zero-bubble handoff and a per-grant hold limit.

module ring_token_arbiter_lane #(
  parameter int NUM_LANES = 4,
  parameter int IDX       = 0,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [IDX_W-1:0]     ptr_idx,
  output logic                 win
);
  logic [IDX_W-1:0] d_self;

  // Scan distance from the token wraps naturally in IDX_W bits (NUM_LANES is 2**IDX_W).
  always_comb begin
    d_self = IDX_W'(IDX) - ptr_idx;
    win    = req[IDX];
    for (int j = 0; j < NUM_LANES; j++) begin
      if (j != IDX && req[j] && ((IDX_W'(j) - ptr_idx) < d_self)) win = 1'b0;
    end
  end
endmodule

module ring_token_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = 2;
  localparam logic [7:0]  HOLD_LIM  = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   ptr_q, ptr_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [NUM_LANES-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_LANES-1:0]   arb_req, arb_ptr, arb_win, ptr_rot;
  logic [IDX_W-1:0]       arb_ptr_idx, arb_win_id;
  logic                   rel_drop, rel_done, rel_limit, rel_any;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ring_token_arbiter_lane #(
      .NUM_LANES (NUM_LANES),
      .IDX       (i),
      .IDX_W     (IDX_W)
    ) u_lane (
      .req     (arb_req),
      .ptr_idx (arb_ptr_idx),
      .win     (arb_win[i])
    );
  end

  // Release classification; limit only counts when neither drop nor done applies.
  always_comb begin
    rel_drop  = (state_q == GRANT) && !req[grant_id_q];
    rel_done  = (state_q == GRANT) && done;
    rel_limit = (state_q == GRANT) && (hold_cnt_q == HOLD_LIM) && !rel_drop && !rel_done;
    rel_any   = rel_drop || rel_done || rel_limit;
    ptr_rot   = {grant_q[NUM_LANES-2:0], grant_q[NUM_LANES-1]};
  end

  // One arbiter serves both idle entry (current token) and handoff (rotated token).
  always_comb begin
    if (state_q == IDLE) begin
      arb_req = req;
      arb_ptr = ptr_q;
    end else begin
      arb_req = rel_drop ? (req & ~grant_q) : req;
      arb_ptr = ptr_rot;
    end
    arb_ptr_idx = '0;
    arb_win_id  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (arb_ptr[i]) arb_ptr_idx = arb_ptr_idx | IDX_W'(i);
      if (arb_win[i]) arb_win_id  = arb_win_id  | IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d    = arb_win;
          grant_id_d = arb_win_id;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!rel_any) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          ptr_d      = ptr_rot;
          timeout_d  = rel_limit;
          hold_cnt_d = '0;
          if (arb_win != '0) begin
            grant_d    = arb_win;
            grant_id_d = arb_win_id;
            busy_d     = 1'b1;
          end else begin
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 4'b0001;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboard bench for ring_token_arbiter: directed scenarios with fixed expectations,
// then a randomized run against a behavioral reference model.

module tb_ring_token_arbiter;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy, timeout;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // reference model state
  logic       m_st;
  logic [3:0] m_ptr, m_g;
  int         m_hold;
  logic       m_to;

  ring_token_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  function automatic logic [7:0] pk(input logic [3:0] g, input logic to);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
    return {to, |g, id, g};
  endfunction

  function automatic logic [7:0] obs();
    return {timeout, busy, grant_id, grant};
  endfunction

  task automatic tick(input logic r, input logic [3:0] rq, input logic d);
    reset = r;
    req   = rq;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b1, 4'b0000, 1'b0);
  endtask

  function automatic logic [3:0] m_arb(input logic [3:0] r, input logic [3:0] p);
    int s;
    logic [3:0] w;
    s = 0;
    w = 4'b0000;
    for (int i = 0; i < 4; i++) if (p[i]) s = i;
    for (int k = 3; k >= 0; k--) if (r[(s + k) % 4]) w = 4'b0001 << ((s + k) % 4);
    return w;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
    logic a, b, c;
    int o;
    logic [3:0] w;
    m_to = 1'b0;
    if (r) begin
      m_st = 1'b0; m_ptr = 4'b0001; m_hold = 0; m_g = 4'b0000;
    end else if (!m_st) begin
      if (rq != 4'b0000) begin
        m_g = m_arb(rq, m_ptr); m_hold = 0; m_st = 1'b1;
      end
    end else begin
      o = 0;
      for (int i = 0; i < 4; i++) if (m_g[i]) o = i;
      a = !rq[o];
      b = d;
      c = (m_hold == MAXH - 1) && !a && !b;
      if (!(a || b || c)) begin
        m_hold = m_hold + 1;
      end else begin
        m_ptr = 4'b0001 << ((o + 1) % 4);
        w = m_arb(a ? (rq & ~m_g) : rq, m_ptr);
        m_to = c;
        m_hold = 0;
        if (w != 4'b0000) m_g = w;
        else begin m_g = 4'b0000; m_st = 1'b0; end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(4'b0000, 1'b0));
      tick(1'b1, 4'b0100, 1'b1);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  // single request, done release, then wrap from ptr=1000 and same-edge handoff on drop
  task automatic test_single_and_wrap();
    logic [3:0] rq[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1001, 4'b0001, 4'b0000};
    logic       dn[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] eg[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pk(eg[i], 1'b0));
      tick(1'b0, rq[i], dn[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL single_wrap step=%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    logic d;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      d = (k >= 3) && (k % 2 == 1);
      exp_q.push_back(pk(4'b0001 << (((k - 1) / 2) % 4), 1'b0));
      tick(1'b0, 4'b1111, d);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL round_robin edge=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    exp_q.push_back(pk(4'b0000, 1'b0));
    tick(1'b0, 4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL round_robin_idle got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_hold_limit();
    logic [7:0] e;
    logic [3:0] g;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      g = (k >= 9 && k <= 16) ? 4'b0010 : 4'b0001;
      exp_q.push_back(pk(g, (k == 9) || (k == 17)));
      tick(1'b0, 4'b0011, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL hold_limit edge=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_lone_owner();
    logic [7:0] e;
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      exp_q.push_back(pk(4'b1000, (k > 1) && ((k - 1) % MAXH == 0)));
      tick(1'b0, 4'b1000, 1'b0);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL lone_owner edge=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  // ptr moved to 0010 before reset; the first grant afterwards must follow 0001
  task automatic test_reset_mid_and_coincide();
    logic [3:0] rq[4] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
    logic       dn[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       rs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] eg[4] = '{4'b0001, 4'b0010, 4'b0010, 4'b0000};
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pk(eg[i], 1'b0));
      tick(rs[i], rq[i], dn[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid step=%0d got=%h exp=%h", i, obs(), e);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(pk((k >= 9) ? 4'b0010 : 4'b0001, 1'b0));
      tick(1'b0, 4'b1111, k == 9);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL done_at_limit edge=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    logic [3:0] rq;
    logic r, d;
    do_reset();
    model_step(1'b1, 4'b0000, 1'b0);
    rq = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 4) == 0);
      model_step(r, rq, d);
      exp_q.push_back(pk(m_g, m_to));
      tick(r, rq, d);
      e = exp_q.pop_front();
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL random cyc=%0d req=%b done=%b rst=%b got=%h exp=%h", k, rq, d, r, obs(), e);
      end
      n_chk++;
      if (((grant & ~rq) !== 4'b0000) || ($countones(grant) > 1)) begin
        n_fail++;
        $display("FAIL grant_legal cyc=%0d grant=%b req=%b need onehot subset of req", k, grant, rq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_and_wrap();
    test_round_robin();
    test_hold_limit();
    test_lone_owner();
    test_reset_mid_and_coincide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
